huffman_stream_packer: RTL and testbench
========================================

Name: huffman_stream_packer

Overview:
- Parametrised successor to the fixed 10-bit parallel Huffman output stage.
- Accepts variable-length codes (code + length) from the Huffman coder through a valid/ready handshake and packs them MSB-first into a continuous stream of fixed-width words.
- Adds backpressure, flush with a partial-word tail, an error flag for illegal lengths, and a running bit counter.
- Sits between huffman_coder and the pad-level output mux.

Parameters:
- CODE_W, 10, maximum code length in bits; code occupies code_in[len-1:0].
- LEN_W, 4, width of the length field; must satisfy 2^LEN_W > CODE_W.
- OUT_W, 8, output word width.
- CNT_W, 16, width of the emitted-bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  code/length present.
- in_ready  out  1  packer can accept this cycle.
- code_in  in  CODE_W  right-aligned code; bits above len ignored.
- len_in  in  LEN_W  code length in bits, 0..CODE_W.
- flush  in  1  single-cycle pulse: drain everything, pad the tail.
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts word.
- out_data  out  OUT_W  packed word; first stream bit in MSB.
- out_nbits  out  clog2(OUT_W+1)  valid bits in out_data: OUT_W, or the tail count when out_last.
- out_last  out  1  final (possibly partial) word of a flush.
- flush_done  out  1  one-cycle pulse when the flush completes.
- len_err  out  1  sticky; set when len_in > CODE_W is accepted.
- bits_total  out  CNT_W  total valid bits emitted, wraps modulo 2^CNT_W.

Behaviour:
- Storage is a left-aligned accumulator acc of width ACC_W = OUT_W+CODE_W, plus a fill counter.
- Reset:
  - acc, fill and bits_total = 0.
  - State RUN; len_err = 0.
  - out_valid, out_last and flush_done = 0; in_ready = 1.
- Accept: in_valid && in_ready at edge t. The code's len bits, MSB first, are written at acc[ACC_W-1-fill downto ACC_W-fill-len]; fill += len. The result is visible at t+1.
- len_in = 0: handshake completes, nothing changes.
- len_in > CODE_W: treated as CODE_W, len_err set (sticky until reset).
- in_ready = (state == RUN) && (fill <= OUT_W). This guarantees room for a max-length code even with no emit in the same cycle.
- out_valid in RUN = (fill >= OUT_W). In that case out_data = acc[ACC_W-1 -: OUT_W], out_nbits = OUT_W, out_last = 0.
- Emit (out_valid && out_ready): acc <<= OUT_W, fill -= OUT_W, bits_total += out_nbits.
- Simultaneous accept and emit in one cycle:
  - fill_next = fill + len − OUT_W.
  - The new code is placed relative to the shifted accumulator, at position ACC_W-1-(fill-OUT_W).
- States:
  - RUN: flush pulse → DRAIN. A flush in the same cycle as an accept still accepts that code.
  - DRAIN: in_ready = 0.
    - While fill >= OUT_W, emit full words as in RUN.
    - When 0 < fill < OUT_W: out_valid = 1, out_data = top bits with zero padding below, out_nbits = fill, out_last = 1. On handshake: fill = 0 → DONE.
    - When fill == 0 (including an empty flush): → DONE, no word emitted.
    - If fill is an exact multiple of OUT_W, the last full word does not carry out_last. The flush ends with no tail word.
  - DONE: flush_done = 1 for one cycle → RUN.
- Flush pulses in DRAIN or DONE are ignored.
- Output stability: out_data, out_nbits and out_last stay stable while out_valid && !out_ready.
- Reset mid-operation: the synchronous reset wins over every event in that cycle. Pending bits are discarded and nothing is emitted.
- bits_total wraps silently.

Decomposition:
- Shared package huffman_pkg:
  - CODE_W/LEN_W defaults matching huffman_coder.
  - State encoding (RUN, DRAIN, DONE).
  - A clog2 helper function.
- One natural sub-module: bit_insert_shifter. It is combinational and produces the acc OR-mask for (code, len, position). Both the plain and the accept+emit paths use it.
- Handshake and FSM live in the top.

Test Plan (OUT_W=8, CODE_W=10):
- Pack: accept 101 (len 3), then 11001 (len 5), out_ready = 1 → cycle after second accept: out_valid = 1, out_data = 0xB9, out_nbits = 8; fill returns to 0; bits_total = 8.
- Straddle: accept 1111111111 (len 10), then 01 (len 2) → word 0xFF; then, after flush, tail 0b11010000 with out_nbits = 4, out_last = 1; flush_done pulses one cycle later.
- Backpressure: out_ready = 0 with fill = 9 → in_ready = 0; out_data held constant for 5 cycles; releasing out_ready emits the word and in_ready returns to 1.
- Empty flush: flush with fill = 0 → no out_valid, flush_done pulse exactly 2 cycles after the flush; an exact-multiple flush (16 bits) emits two words, neither with out_last.
- Errors and edges: len_in = 15 → treated as 10 bits, len_err = 1 and stays set; len_in = 0 → handshake completes, fill unchanged.
- Reset mid-DRAIN: pending fill = 5, reset → next cycle out_valid = 0, in_ready = 1, bits_total = 0, len_err = 0.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman coder and stream packer:
// default widths, packer FSM encoding and a clog2 helper.
package huffman_pkg;

    localparam int unsigned HUFF_CODE_W = 10;
    localparam int unsigned HUFF_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/huffman_stream_packer_if.sv
// Code input stream and packed word output stream of the Huffman packer.
interface huffman_stream_packer_if
    import huffman_pkg::*;
#(
    parameter int unsigned CODE_W = HUFF_CODE_W,
    parameter int unsigned LEN_W  = HUFF_LEN_W,
    parameter int unsigned OUT_W  = 8
);
    localparam int unsigned NB_W = clog2(OUT_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code_in;
    logic [LEN_W-1:0]  len_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [NB_W-1:0]   out_nbits;
    logic              out_last;

    // Packer side
    modport slave (
        input  in_valid, code_in, len_in, out_ready,
        output in_ready, out_valid, out_data, out_nbits, out_last
    );

    // Producer/sink side
    modport master (
        output in_valid, code_in, len_in, out_ready,
        input  in_ready, out_valid, out_data, out_nbits, out_last
    );

endinterface

// File: rtl/huffman_stream_packer_bit_insert_shifter.sv
// OR-mask that places the low len bits of code, MSB first, starting
// pos bits below the top of a left-aligned accumulator.
module bit_insert_shifter #(
    parameter int unsigned CODE_W = 10,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned ACC_W  = 18,
    parameter int unsigned POS_W  = 5
) (
    input  logic [CODE_W-1:0] code,
    input  logic [LEN_W-1:0]  len,
    input  logic [POS_W-1:0]  pos,
    output logic [ACC_W-1:0]  mask_c
);

    logic [ACC_W-1:0] len_mask;
    logic [ACC_W-1:0] code_ext;
    logic [POS_W:0]   end_pos;

    always_comb begin
        len_mask = ~({ACC_W{1'b1}} << len);
        code_ext = ACC_W'(code) & len_mask;
        end_pos  = (POS_W+1)'(pos) + (POS_W+1)'(len);
        mask_c   = '0;
        if (end_pos <= (POS_W+1)'(ACC_W)) begin
            mask_c = code_ext << ((POS_W+1)'(ACC_W) - end_pos);
        end
    end

endmodule

// File: rtl/huffman_stream_packer.sv
// Packs variable-length Huffman codes MSB-first into OUT_W-bit words,
// with backpressure, flush with partial tail and an emitted-bit counter.
module huffman_stream_packer
    import huffman_pkg::*;
#(
    parameter int unsigned CODE_W = HUFF_CODE_W,
    parameter int unsigned LEN_W  = HUFF_LEN_W,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    huffman_stream_packer_if.slave  bus,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    len_err,
    output logic [CNT_W-1:0]        bits_total
);

    localparam int unsigned ACC_W = OUT_W + CODE_W;
    localparam int unsigned FW    = clog2(ACC_W + 1);
    localparam int unsigned NB_W  = clog2(OUT_W + 1);

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [FW-1:0]    fill_q;

    logic             len_over;
    logic [LEN_W-1:0] len_eff;
    logic             accept;
    logic             emit;
    logic [ACC_W-1:0] acc_base;
    logic [FW-1:0]    fill_base;
    logic [ACC_W-1:0] ins_mask_c;
    logic [ACC_W-1:0] acc_d;
    logic [FW-1:0]    fill_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (fill_q == '0 || (emit && bus.out_last)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Outputs depend only on registered state, fill and accumulator
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = acc_q[ACC_W-1 -: OUT_W];
        bus.out_nbits = NB_W'(OUT_W);
        bus.out_last  = 1'b0;
        flush_done    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                bus.in_ready  = (fill_q <= FW'(OUT_W));
                bus.out_valid = (fill_q >= FW'(OUT_W));
            end
            ST_DRAIN: begin
                if (fill_q >= FW'(OUT_W)) begin
                    bus.out_valid = 1'b1;
                end else if (fill_q != '0) begin
                    bus.out_valid = 1'b1;
                    bus.out_nbits = NB_W'(fill_q);
                    bus.out_last  = 1'b1;
                end
            end
            ST_DONE: flush_done = 1'b1;
            default: ;
        endcase
    end

    // Accumulator after any emit this cycle; new code is placed relative to it
    always_comb begin
        len_over  = (bus.len_in > LEN_W'(CODE_W));
        len_eff   = len_over ? LEN_W'(CODE_W) : bus.len_in;
        accept    = bus.in_valid && bus.in_ready;
        emit      = bus.out_valid && bus.out_ready;
        acc_base  = acc_q;
        fill_base = fill_q;
        if (emit && bus.out_last) begin
            acc_base  = '0;
            fill_base = '0;
        end else if (emit) begin
            acc_base  = acc_q << OUT_W;
            fill_base = fill_q - FW'(OUT_W);
        end
    end

    bit_insert_shifter #(
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W),
        .POS_W  (FW)
    ) u_shifter (
        .code   (bus.code_in),
        .len    (len_eff),
        .pos    (fill_base),
        .mask_c (ins_mask_c)
    );

    always_comb begin
        acc_d  = acc_base;
        fill_d = fill_base;
        if (accept) begin
            acc_d  = acc_base | ins_mask_c;
            fill_d = fill_base + FW'(len_eff);
        end
    end

    // Datapath registers; reset discards pending bits
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            fill_q     <= '0;
            bits_total <= '0;
            len_err    <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            if (emit) begin
                bits_total <= bits_total + CNT_W'(bus.out_nbits);
            end
            if (accept && len_over) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_stream_packer.sv
// Directed bench for huffman_stream_packer; expected words go through a
// queue checked by an independent output monitor.
module tb_huffman_stream_packer;

    localparam int unsigned CODE_W = 10;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       last;
    } word_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             flush_done;
    logic             len_err;
    logic [CNT_W-1:0] bits_total;

    int    tests  = 0;
    int    errors = 0;
    word_t exp_q[$];
    word_t mon_e;

    huffman_stream_packer_if #(.CODE_W(CODE_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) bus ();

    huffman_stream_packer #(
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W),
        .OUT_W  (OUT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .len_err    (len_err),
        .bits_total (bits_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] n, input logic l);
        word_t w;
        w.data  = d;
        w.nbits = n;
        w.last  = l;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [9:0] code, input logic [3:0] len);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.code_in  = code;
        bus.len_in   = len;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!flush_done && n < 50) begin
            step();
            n++;
        end
        chk("flush_done_seen", 32'(flush_done), 32'd1);
        step();
    endtask

    // Monitor: every handshaken output word is compared against the queue
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_word: got data 0x%0h nbits %0d last %0d, expected no word",
                         bus.out_data, bus.out_nbits, bus.out_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_data",  32'(bus.out_data),  32'(mon_e.data));
                chk("word_nbits", 32'(bus.out_nbits), 32'(mon_e.nbits));
                chk("word_last",  32'(bus.out_last),  32'(mon_e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.code_in   = '0;
        bus.len_in    = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",   32'(bus.in_ready),  32'd1);
        chk("rst_len_err",    32'(len_err),       32'd0);
        chk("rst_bits_total", 32'(bits_total),    32'd0);
        chk("rst_flush_done", 32'(flush_done),    32'd0);

        // Pack: 101 + 11001 -> 0xB9
        push(8'hB9, 4'd8, 1'b0);
        send(10'b101, 4'd3);
        send(10'b11001, 4'd5);
        chk("pack_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("pack_bits_total", 32'(bits_total), 32'd8);
        chk("pack_in_ready",   32'(bus.in_ready), 32'd1);

        // Straddle: ten ones then 01 -> 0xFF, tail 1101 padded
        push(8'hFF, 4'd8, 1'b0);
        send(10'b1111111111, 4'd10);
        send(10'b01, 4'd2);
        push(8'b1101_0000, 4'd4, 1'b1);
        do_flush();
        chk("strad_done_early", 32'(flush_done), 32'd0);
        step();
        chk("strad_done_pulse", 32'(flush_done), 32'd1);
        step();
        chk("strad_done_clear", 32'(flush_done), 32'd0);
        chk("strad_bits_total", 32'(bits_total), 32'd20);

        // Backpressure with 9 bits pending
        bus.out_ready = 1'b0;
        send(10'b0101010101, 4'd9);
        chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", 32'(bus.out_data), 32'hAA);
            step();
        end
        push(8'hAA, 4'd8, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        push(8'h80, 4'd1, 1'b1);
        do_flush();
        wait_done();
        chk("bp_bits_total", 32'(bits_total), 32'd29);

        // Empty flush
        do_flush();
        chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_done_early", 32'(flush_done), 32'd0);
        step();
        chk("empty_done_pulse", 32'(flush_done), 32'd1);
        chk("empty_out_valid2", 32'(bus.out_valid), 32'd0);
        step();

        // Exact multiple: 16 bits held, then drained as two full words
        bus.out_ready = 1'b0;
        send(10'hCC, 4'd8);
        send(10'hD5, 4'd8);
        chk("exact_in_ready", 32'(bus.in_ready), 32'd0);
        push(8'hCC, 4'd8, 1'b0);
        push(8'hD5, 4'd8, 1'b0);
        do_flush();
        bus.out_ready = 1'b1;
        wait_done();
        chk("exact_bits_total", 32'(bits_total), 32'd45);

        // Illegal length clamps to 10, zero length is a no-op, upper code bits ignored
        push(8'hFF, 4'd8, 1'b0);
        send(10'h3FF, 4'd15);
        chk("err_len_err", 32'(len_err), 32'd1);
        send(10'h005, 4'd0);
        push(8'hC0, 4'd8, 1'b0);
        send(10'b1111000000, 4'd6);
        step();
        step();
        chk("err_len_err_sticky", 32'(len_err), 32'd1);
        chk("err_bits_total", 32'(bits_total), 32'd61);
        chk("err_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset while a 5-bit tail waits in DRAIN
        bus.out_ready = 1'b0;
        send(10'b10110, 4'd5);
        do_flush();
        chk("mid_tail_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_tail_last",  32'(bus.out_last),  32'd1);
        chk("mid_tail_nbits", 32'(bus.out_nbits), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",   32'(bus.in_ready),  32'd1);
        chk("mid_rst_bits_total", 32'(bits_total),    32'd0);
        chk("mid_rst_len_err",    32'(len_err),       32'd0);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
